stream_nto1_mux: RTL and testbench

//   Registered N:1 stream multiplexer with valid/ready handshake; parametrised successor of the 2:1 mux.

---
 rtl/stream_nto1_mux.sv | 74 +++++++
 tb/tb_stream_nto1_mux.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/stream_nto1_mux.sv
// stream_nto1_mux: registered N:1 valid/ready stream mux, select-driven or round-robin
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_data    NUM_CH packed channels, channel i at [i*DATA_W +: DATA_W]
//   in_valid   per-channel valid
//   in_ready   per-channel ready, one-hot or zero
//   sel        channel select, used only when RR_MODE=0
//   out_data   registered output beat
//   out_valid  output register holds a beat
//   out_ready  consumer accepts the beat
//   out_ch     source channel of the beat in out_data
module stream_nto1_mux #(
    parameter int DATA_W  = 8,
    parameter int NUM_CH  = 4,
    parameter int SEL_W   = 2,
    parameter int RR_MODE = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    input  logic [NUM_CH-1:0]        in_valid,
    output logic [NUM_CH-1:0]        in_ready,
    input  logic [SEL_W-1:0]         sel,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [SEL_W-1:0]         out_ch
);
    typedef enum logic {EMPTY, FULL} state_t;
    state_t           state;
    logic [SEL_W-1:0] rr_ptr;
    logic [SEL_W-1:0] g;
    logic [SEL_W-1:0] idx;
    logic             grant;
    logic             can_load;
    logic             xfer;
    assign out_valid = state == FULL;
    assign can_load  = state == EMPTY || out_ready;
    // Round-robin scans from the farthest offset down so the channel nearest rr_ptr wins last.
    always_comb begin
        g     = '0;
        grant = 1'b0;
        idx   = '0;
        if (RR_MODE == 0) begin
            g     = sel;
            grant = 32'(sel) < NUM_CH;
        end else begin
            for (int k = NUM_CH - 1; k >= 0; k--) begin
                idx = SEL_W'((32'(rr_ptr) + 32'(k)) % NUM_CH);
                if (in_valid[idx]) begin
                    g     = idx;
                    grant = 1'b1;
                end
            end
        end
    end
    assign in_ready = (rst_n && can_load && grant) ? NUM_CH'(1) << g : '0;
    assign xfer     = |(in_valid & in_ready);
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= EMPTY;
            out_data <= '0;
            out_ch   <= '0;
            rr_ptr   <= '0;
        end else if (xfer) begin
            state    <= FULL;
            out_data <= in_data[g*DATA_W +: DATA_W];
            out_ch   <= g;
            if (RR_MODE != 0) rr_ptr <= SEL_W'((32'(g) + 1) % NUM_CH);
        end else if (out_ready) begin
            state <= EMPTY;
        end
    end
endmodule

// File: tb/tb_stream_nto1_mux.sv
// tb_stream_nto1_mux: checks select, round-robin and 3-channel instances against a behavioural model
module tb_stream_nto1_mux;
    localparam int NCH[3] = '{4, 4, 3};
    localparam int RR[3]  = '{0, 1, 0};
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_data = '0;
    logic [3:0]  in_valid = '0;
    logic [1:0]  sel = '0;
    logic [3:0]  rdy0, rdy1;
    logic [2:0]  rdy2;
    logic [7:0]  od[3];
    logic        ov[3];
    logic [1:0]  oc[3];
    int          checks = 0;
    int          errors = 0;
    bit          m_v[3];
    logic [7:0]  m_d[3];
    int          m_c[3];
    int          m_p[3];
    always #5 clk = ~clk;
    stream_nto1_mux #(.DATA_W(8), .NUM_CH(4), .SEL_W(2), .RR_MODE(0)) u0 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy0),
        .sel(sel), .out_data(od[0]), .out_valid(ov[0]), .out_ready(out_ready), .out_ch(oc[0]));
    stream_nto1_mux #(.DATA_W(8), .NUM_CH(4), .SEL_W(2), .RR_MODE(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy1),
        .sel(sel), .out_data(od[1]), .out_valid(ov[1]), .out_ready(out_ready), .out_ch(oc[1]));
    stream_nto1_mux #(.DATA_W(8), .NUM_CH(3), .SEL_W(2), .RR_MODE(0)) u2 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data[23:0]), .in_valid(in_valid[2:0]), .in_ready(rdy2),
        .sel(sel), .out_data(od[2]), .out_valid(ov[2]), .out_ready(out_ready), .out_ch(oc[2]));
    function automatic logic [3:0] rdy_of(int d);
        return d == 0 ? rdy0 : d == 1 ? rdy1 : {1'b0, rdy2};
    endfunction
    // Channel that the spec's grant rule picks, or -1 when nothing is granted.
    function automatic int grant_of(int d);
        if (RR[d] == 0) return int'(sel) < NCH[d] ? int'(sel) : -1;
        for (int k = 0; k < NCH[d]; k++) begin
            int i = (m_p[d] + k) % NCH[d];
            if (in_valid[i]) return i;
        end
        return -1;
    endfunction
    task automatic chk(string tag, int d, logic [31:0] o, logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s dut%0d: got %0h expected %0h", tag, d, o, e);
        end
    endtask
    // One clock: check in_ready before the edge, advance the model, check outputs after it.
    task automatic cyc();
        int g[3];
        bit x[3];
        #1;
        for (int d = 0; d < 3; d++) begin
            bit can = !m_v[d] || out_ready;
            g[d] = grant_of(d);
            chk("in_ready", d, 32'(rdy_of(d)), (rst_n && can && g[d] >= 0) ? 32'(1 << g[d]) : 32'd0);
            x[d] = rst_n && can && g[d] >= 0 && in_valid[g[d]];
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            if (!rst_n) begin
                m_v[d] = 0; m_d[d] = '0; m_c[d] = 0; m_p[d] = 0;
            end else if (x[d]) begin
                m_v[d] = 1;
                m_d[d] = in_data[g[d]*8 +: 8];
                m_c[d] = g[d];
                if (RR[d] != 0) m_p[d] = (g[d] + 1) % NCH[d];
            end else if (out_ready) begin
                m_v[d] = 0;
            end
            chk("out_valid", d, 32'(ov[d]), 32'(m_v[d]));
            chk("out_data", d, 32'(od[d]), 32'(m_d[d]));
            chk("out_ch", d, 32'(oc[d]), 32'(m_c[d]));
        end
        @(negedge clk);
    endtask
    initial begin
        for (int d = 0; d < 3; d++) begin
            m_v[d] = 0; m_d[d] = '0; m_c[d] = 0; m_p[d] = 0;
        end
        rst_n = 0; in_valid = 4'b1111; out_ready = 1; in_data = $urandom;
        cyc();
        cyc();
        chk("rst_valid", 0, 32'(ov[0]), 32'd0);
        chk("rst_data", 0, 32'(od[0]), 32'd0);
        rst_n = 1; sel = 2; in_data = 32'h00A5_0000; in_valid = 4'b0100;
        cyc();
        chk("sel_data", 0, 32'(od[0]), 32'hA5);
        chk("sel_ch", 0, 32'(oc[0]), 32'd2);
        chk("sel_valid", 0, 32'(ov[0]), 32'd1);
        in_valid = 4'b0000;
        cyc();
        sel = 1; in_data = 32'h0000_3C00; in_valid = 4'b0010; out_ready = 0;
        cyc();
        for (int i = 0; i < 3; i++) begin
            in_valid = 4'b1111; in_data = $urandom;
            cyc();
            chk("stall_data", 0, 32'(od[0]), 32'h3C);
            chk("stall_rdy", 0, 32'(rdy0), 32'd0);
        end
        out_ready = 1;
        #1 chk("release_rdy", 0, 32'(rdy0), 32'b0010);
        cyc();
        rst_n = 0;
        cyc();
        rst_n = 1; in_valid = 4'b1111; sel = 0;
        for (int i = 0; i < 6; i++) begin
            in_data = $urandom;
            cyc();
            chk("rr_seq", 1, 32'(oc[1]), 32'(i % 4));
            chk("rr_valid", 1, 32'(ov[1]), 32'd1);
        end
        rst_n = 0;
        cyc();
        rst_n = 1; in_valid = 4'b0001;
        cyc();
        in_valid = 4'b1001;
        cyc();
        chk("rr_skip3", 1, 32'(oc[1]), 32'd3);
        cyc();
        chk("rr_skip0", 1, 32'(oc[1]), 32'd0);
        rst_n = 0;
        cyc();
        rst_n = 1; sel = 3; in_valid = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("oor_rdy", 2, 32'(rdy2), 32'd0);
            chk("oor_valid", 2, 32'(ov[2]), 32'd0);
        end
        for (int i = 0; i < 400; i++) begin
            rst_n = $urandom_range(0, 39) != 0;
            in_valid = 4'($urandom);
            in_data = $urandom;
            sel = 2'($urandom);
            out_ready = $urandom_range(0, 3) != 0;
            cyc();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
